tx_packetizer: RTL and testbench
================================

# tx_packetizer

Transmit-side framing stage that sits directly upstream of the shared-bus interface. It buffers payload bytes from a crypto core and, on request, builds a one-byte header carrying source and destination IDs. It requests the bus from the arbiter and streams header plus payload on the `send_valid`/`send_data`/`send_ready` handshake, asserting `ack` with the final byte. A packet is launched only when its whole payload is already buffered, so the bus never stalls mid-packet.

## Interface
- `DEPTH`, 16: payload FIFO depth in bytes; power of two, at least `MAX_LEN`.
- `MAX_LEN`, 16: maximum payload bytes per packet, range 1..63.
- Reset and clock: `rst_n` is asynchronous and active-low; the clock is `clk`.
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `source_id`  in  2  this node's ID, static
- `req_valid`  in  1  packet request
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_type`  in  2  header[7:6]
- `req_dest`  in  2  header[3:2]
- `req_len`  in  6  payload length; 0 or greater than `MAX_LEN` is illegal
- `pay_valid`  in  1  payload byte write
- `pay_data`  in  8  payload byte
- `pay_ready`  out  1  FIFO not full
- `bus_req`  out  1  request to arbiter
- `bus_grant`  in  1  grant from arbiter
- `send_valid`  out  1  byte on `send_data` is valid
- `send_data`  out  8  outgoing byte
- `send_ready`  in  1  bus interface is accepting; one byte transfers per cycle while high
- `ack`  out  1  current byte is the last of the packet
- `busy`  out  1  state is not IDLE
- `err_pulse`  out  1  one-cycle pulse on illegal request or on abort

## Operation
- Header byte: `{req_type, source_id, req_dest, 2'b00}`.
- A byte transfers on any cycle where `send_valid && send_ready`.
- State machine:
  - **IDLE**: `req_ready=1`. On acceptance, latch type, destination and length.
    - Illegal `req_len`: pulse `err_pulse`, stay in IDLE.
    - Otherwise go to WAIT.
  - **WAIT**: `req_ready=0`. When FIFO count is at least the latched length, raise `bus_req` and go to REQ.
  - **REQ**: `bus_req=1`. On `bus_grant`, go to HDR.
  - **HDR**: `send_valid=1`, `send_data=header`. When a transfer occurs, go to PAY.
  - **PAY**: `send_valid=1`, `send_data` = FIFO head (first-word fall-through). Each transfer pops the FIFO and decrements the remaining count. `ack=1` when remaining count is 1. The transfer of that last byte moves to DONE.
  - **DONE**: all outputs low for exactly one cycle, `bus_req` included. Then go to IDLE.
- Grant lost in HDR or PAY (`bus_grant=0`):
  - Move to FLUSH and pulse `err_pulse`.
  - Drop `bus_req`, `send_valid` and `ack` immediately.
- **FLUSH**: pop one FIFO byte per cycle until the remaining count is 0, then go to IDLE. Remaining bytes of the aborted packet are discarded.
- Grant lost in REQ: no effect; keep `bus_req` high.
- FIFO:
  - Writes are accepted when `pay_valid && pay_ready`.
  - Simultaneous push and pop with the FIFO full is allowed; `pay_ready` is based on the registered count.
  - Pointers wrap modulo `DEPTH`.
  - Count width is `$clog2(DEPTH)+1`.

## Timing
- Reset values: `req_ready=0` for one cycle after reset, then 1. All other outputs are 0 (`bus_req`, `send_valid`, `send_data=8'h00`, `ack`, `busy`, `err_pulse`). `pay_ready=1`.
- All outputs are registered, except `send_data` and `ack` in PAY, which are combinational from the FIFO head and the remaining count.
- Latency:
  - Request accepted with payload already buffered: `bus_req` high 2 cycles later.
  - Grant to header valid: 1 cycle.
- Packet of N bytes with `send_ready` continuously high: N+1 consecutive cycles of `send_valid`.
- The bus interface raises `send_ready` one cycle after `send_valid`, so the header is held at least 2 cycles.
- Reset mid-packet: immediate return to IDLE and FIFO cleared.

## Configuration
- `TX_CHECKSUM_EN` defined:
  - A checksum byte follows the last payload byte. It is the XOR of the header and all payload bytes.
  - `ack` moves to the checksum byte, and a CKSUM state is added between PAY and DONE.
  - A packet is N+2 bytes.
- Not defined: no checksum byte; `ack` is on the last payload byte.

## Structure
- `bus_pkg` (shared):
  - Header field positions (TYPE [7:6], SRC [5:4], DST [3:2]).
  - Node ID constants.
  - Packet type encodings.
  - State enum `tx_state_t`.
- Sub-module `tx_fifo`: synchronous FIFO with first-word fall-through, count output, parameter `DEPTH`.

## Test plan
- `source_id=2'b01`, request type 2'b10, dest 2'b11, len 3, payload 0xA1/0xB2/0xC3, grant held → bytes 0x9C, 0xA1, 0xB2, 0xC3; `ack` only on 0xC3; then DONE, IDLE.
- Request len 4 with only 2 bytes buffered → `bus_req` stays 0 until the 4th byte is written, then rises 1 cycle later.
- `bus_grant` dropped after the 2nd payload byte of a len-5 packet → `err_pulse` once; 3 bytes flushed; FIFO count 0; back in IDLE.
- `req_len=0` and `req_len=MAX_LEN+1` → `err_pulse`, no `bus_req`, state stays IDLE.
- Fill the FIFO to DEPTH, then push and pop simultaneously across the wrap point → no byte lost or duplicated; `pay_ready` deasserts only when full.
- With `TX_CHECKSUM_EN`, the first scenario → extra byte 0x9C^0xA1^0xB2^0xC3 = 0x4C, carrying `ack`.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared-bus header layout, node IDs, packet types and transmit state encoding.
package bus_pkg;
  localparam int HDR_TYPE_LSB = 6;
  localparam int HDR_SRC_LSB = 4;
  localparam int HDR_DST_LSB = 2;
  localparam logic [1:0] NODE_CPU = 2'd0;
  localparam logic [1:0] NODE_CRYPTO = 2'd1;
  localparam logic [1:0] NODE_DMA = 2'd2;
  localparam logic [1:0] NODE_IO = 2'd3;
  localparam logic [1:0] PKT_DATA = 2'd0;
  localparam logic [1:0] PKT_KEY = 2'd1;
  localparam logic [1:0] PKT_CIPHER = 2'd2;
  localparam logic [1:0] PKT_CTRL = 2'd3;
  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_REQ, ST_HDR, ST_PAY, ST_CKSUM, ST_DONE, ST_FLUSH
  } tx_state_t;
  function automatic logic [7:0] make_header(input logic [1:0] typ, input logic [1:0] src,
                                             input logic [1:0] dst);
    logic [7:0] h;
    h = 8'h00;
    h[HDR_TYPE_LSB +: 2] = typ;
    h[HDR_SRC_LSB +: 2] = src;
    h[HDR_DST_LSB +: 2] = dst;
    return h;
  endfunction
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: synchronous first-word fall-through byte FIFO with occupancy count.
module tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  // A pop frees the slot, so a push alongside it is safe even when full.
  assign do_push = push && (!full || do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/tx_packetizer.sv
// tx_packetizer: buffers payload, then frames and streams header + payload onto the shared bus.
// Define TX_CHECKSUM_EN to append an XOR checksum byte (header ^ payload) carrying ack.
module tx_packetizer
  import bus_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] source_id,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_type,
  input  logic [1:0] req_dest,
  input  logic [5:0] req_len,
  input  logic       pay_valid,
  input  logic [7:0] pay_data,
  output logic       pay_ready,
  output logic       bus_req,
  input  logic       bus_grant,
  output logic       send_valid,
  output logic [7:0] send_data,
  input  logic       send_ready,
  output logic       ack,
  output logic       busy,
  output logic       err_pulse
);
`ifdef TX_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif
  localparam int CW = $clog2(DEPTH) + 1;
  tx_state_t state_q, state_d;
  logic [1:0] type_q, dest_q;
  logic [5:0] len_q, rem_q;
  logic [7:0] cks_q, header, fifo_dout;
  logic [CW-1:0] fifo_count;
  logic fifo_full, push, pop, accept, illegal, xfer, err_d;
  assign pay_ready = !fifo_full;
  assign push = pay_valid && pay_ready;
  assign accept = req_valid && req_ready;
  assign illegal = req_len == 6'd0 || 32'(req_len) > MAX_LEN;
  assign xfer = send_valid && send_ready;
  assign header = make_header(type_q, source_id, dest_q);
  assign send_data = state_q == ST_HDR ? header :
                     state_q == ST_PAY ? fifo_dout :
                     state_q == ST_CKSUM ? cks_q : 8'h00;
  assign ack = (state_q == ST_PAY && rem_q == 6'd1 && !CKS_EN) || state_q == ST_CKSUM;
  tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (pay_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full)
  );
  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    err_d = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = illegal ? ST_IDLE : ST_WAIT;
        err_d = illegal;
      end
      // Counting the byte being written this cycle lets bus_req rise one cycle after the last write.
      ST_WAIT: if (32'(fifo_count) + 32'(push) >= 32'(len_q)) state_d = ST_REQ;
      ST_REQ: if (bus_grant) state_d = ST_HDR;
      ST_HDR: begin
        state_d = !bus_grant ? ST_FLUSH : xfer ? ST_PAY : ST_HDR;
        err_d = !bus_grant;
      end
      ST_PAY: begin
        pop = xfer;
        err_d = !bus_grant;
        if (!bus_grant) state_d = ST_FLUSH;
        else if (xfer && rem_q == 6'd1) state_d = CKS_EN ? ST_CKSUM : ST_DONE;
      end
      ST_CKSUM: begin
        state_d = !bus_grant ? ST_FLUSH : xfer ? ST_DONE : ST_CKSUM;
        err_d = !bus_grant;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FLUSH: begin
        pop = rem_q != 6'd0;
        if (rem_q <= 6'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_ready <= 1'b0;
      bus_req <= 1'b0;
      send_valid <= 1'b0;
      busy <= 1'b0;
      err_pulse <= 1'b0;
      type_q <= 2'd0;
      dest_q <= 2'd0;
      len_q <= 6'd0;
      rem_q <= 6'd0;
      cks_q <= 8'h00;
    end else begin
      state_q <= state_d;
      req_ready <= state_d == ST_IDLE;
      bus_req <= state_d inside {ST_REQ, ST_HDR, ST_PAY, ST_CKSUM};
      send_valid <= state_d inside {ST_HDR, ST_PAY, ST_CKSUM};
      busy <= state_d != ST_IDLE;
      err_pulse <= err_d;
      if (accept) begin
        type_q <= req_type;
        dest_q <= req_dest;
        len_q <= req_len;
        rem_q <= req_len;
      end else if (pop) rem_q <= rem_q - 6'd1;
      if (xfer) cks_q <= state_q == ST_HDR ? header : cks_q ^ fifo_dout;
    end
endmodule

// File: tb/tb_tx_packetizer.sv
// tb_tx_packetizer: table-driven packet vectors plus hand-written abort, wait, wrap and reset sequences.
module tb_tx_packetizer;
`ifdef TX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] source_id = 2'b01, req_type = 2'd0, req_dest = 2'd0;
  logic [5:0] req_len = 6'd0;
  logic req_valid = 1'b0, pay_valid = 1'b0, bus_grant = 1'b1, send_ready = 1'b0;
  logic [7:0] pay_data = 8'h00;
  logic req_ready, pay_ready, bus_req, send_valid, ack, busy, err_pulse;
  logic [7:0] send_data;
  logic rdy_en = 1'b1, last_sv = 1'b0;
  int n_cmp = 0, n_bad = 0, n_err = 0;
  logic [8:0] exp_q[$];
  logic [7:0] pay_model[$], feed_q[$];

  typedef struct {
    logic [1:0] typ;
    logic [1:0] dst;
    logic [5:0] len;
    logic [7:0] base;
    logic [7:0] hdr;
    logic       bad;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  tx_packetizer #(.DEPTH(16), .MAX_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .source_id(source_id),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_dest(req_dest), .req_len(req_len),
    .pay_valid(pay_valid), .pay_data(pay_data), .pay_ready(pay_ready),
    .bus_req(bus_req), .bus_grant(bus_grant),
    .send_valid(send_valid), .send_data(send_data), .send_ready(send_ready),
    .ack(ack), .busy(busy), .err_pulse(err_pulse)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Scoreboard: every bus transfer pops one expected {ack, data}.
  always @(negedge clk) begin
    if (err_pulse) n_err++;
    if (rst_n && send_valid && send_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_byte: got %0h with ack %0b, required no transfer", send_data, ack);
      end else chk("byte", 32'({ack, send_data}), 32'(exp_q.pop_front()));
    end
  end

  // One clock; feeds queued payload and models a bus that raises send_ready a cycle after send_valid.
  task automatic step;
    logic acc;
    pay_valid = feed_q.size() != 0;
    pay_data = pay_valid ? feed_q[0] : 8'h00;
    acc = pay_valid && pay_ready;
    @(posedge clk);
    if (acc) pay_model.push_back(feed_q.pop_front());
    #1;
    send_ready = rdy_en && last_sv;
    last_sv = send_valid;
  endtask

  task automatic wait_feed;
    int t = 0;
    while (feed_q.size() != 0 && t < 100) begin step; t++; end
    if (feed_q.size() != 0) fail("feed_timeout");
  endtask

  task automatic issue(input logic [1:0] typ, input logic [1:0] dst, input logic [5:0] len);
    int t = 0;
    req_type = typ;
    req_dest = dst;
    req_len = len;
    req_valid = 1'b1;
    while (!req_ready && t < 20) begin step; t++; end
    if (!req_ready) fail("req_ready_timeout");
    step;
    req_valid = 1'b0;
  endtask

  task automatic expect_pkt(input logic [7:0] hdr, input int len);
    logic [7:0] c, b;
    c = hdr;
    exp_q.push_back({1'b0, hdr});
    for (int i = 0; i < len; i++) begin
      b = pay_model.pop_front();
      c ^= b;
      exp_q.push_back({i == len - 1 && !CK, b});
    end
    if (CK) exp_q.push_back({1'b1, c});
  endtask

  task automatic finish_pkt;
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin step; t++; end
    chk("pkt_drained", 32'(exp_q.size()), 0);
    chk("done_quiet", 32'({send_valid, bus_req, ack, req_ready}), 0);
    step;
    chk("back_idle", 32'({busy, req_ready}), 32'(2'b01));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e0, t;
    tbl[0] = '{2'b10, 2'b11, 6'd3, 8'hA1, 8'h9C, 1'b0};
    tbl[1] = '{2'b00, 2'b01, 6'd1, 8'h10, 8'h14, 1'b0};
    tbl[2] = '{2'b01, 2'b00, 6'd16, 8'h00, 8'h50, 1'b0};
    tbl[3] = '{2'b11, 2'b10, 6'd0, 8'h00, 8'hD8, 1'b1};
    tbl[4] = '{2'b11, 2'b10, 6'd17, 8'h00, 8'hD8, 1'b1};
    tbl[5] = '{2'b11, 2'b10, 6'd2, 8'hE0, 8'hD8, 1'b0};

    #12;
    chk("reset_outputs", 32'({req_ready, bus_req, send_valid, send_data, ack, busy, err_pulse, pay_ready}), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    chk("req_ready_after_reset", 32'(req_ready), 0);
    step;
    chk("req_ready_second_cycle", 32'(req_ready), 1);

    for (int v = 0; v < 6; v++) begin
      if (!tbl[v].bad) begin
        for (int i = 0; i < int'(tbl[v].len); i++) feed_q.push_back(tbl[v].base + 8'(i) * 8'h11);
        wait_feed;
      end
      e0 = n_err;
      issue(tbl[v].typ, tbl[v].dst, tbl[v].len);
      if (tbl[v].bad) begin
        chk("illegal_err", 32'(err_pulse), 1);
        repeat (3) step;
        chk("illegal_quiet", 32'({bus_req, busy, req_ready}), 32'(3'b001));
        chk("illegal_err_once", 32'(n_err - e0), 1);
      end else begin
        expect_pkt(tbl[v].hdr, int'(tbl[v].len));
        chk("bus_req_lat1", 32'(bus_req), 0);
        step;
        chk("bus_req_lat2", 32'(bus_req), 1);
        step;
        chk("hdr_valid", 32'({send_valid, send_data}), 32'({1'b1, tbl[v].hdr}));
        chk("hdr_held", 32'(send_ready), 0);
        finish_pkt;
      end
    end

    // Request ahead of its payload: bus_req waits for the 4th byte.
    feed_q.push_back(8'h41);
    feed_q.push_back(8'h42);
    wait_feed;
    issue(2'b00, 2'b10, 6'd4);
    for (int i = 0; i < 4; i++) begin
      chk("wait_no_bus_req", 32'(bus_req), 0);
      step;
    end
    feed_q.push_back(8'h43);
    step;
    chk("wait_third_byte", 32'(bus_req), 0);
    feed_q.push_back(8'h44);
    step;
    chk("wait_fourth_byte", 32'(bus_req), 1);
    expect_pkt(8'h18, 4);
    finish_pkt;

    // Grant lost after the 2nd payload byte of a 5-byte packet.
    for (int i = 0; i < 5; i++) feed_q.push_back(8'h61 + 8'(i));
    wait_feed;
    e0 = n_err;
    issue(2'b01, 2'b01, 6'd5);
    exp_q.push_back({1'b0, 8'h54});
    repeat (2) exp_q.push_back({1'b0, pay_model.pop_front()});
    repeat (3) void'(pay_model.pop_front());
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin step; t++; end
    chk("abort_prefix_sent", 32'(exp_q.size()), 0);
    bus_grant = 1'b0;
    rdy_en = 1'b0;
    send_ready = 1'b0;
    step;
    chk("abort_err", 32'(err_pulse), 1);
    chk("abort_drop", 32'({send_valid, bus_req, ack}), 0);
    repeat (3) step;
    chk("flush_idle", 32'(busy), 0);
    chk("flush_count", 32'(dut.fifo_count), 0);
    bus_grant = 1'b1;
    rdy_en = 1'b1;
    step;
    chk("abort_err_once", 32'(n_err - e0), 1);

    // Fill to DEPTH, then stream while refilling across the pointer wrap.
    for (int i = 0; i < 16; i++) feed_q.push_back(8'h80 + 8'(i));
    t = 0;
    while (feed_q.size() != 0 && t < 40) begin
      chk("pay_ready_fill", 32'(pay_ready), 32'(pay_model.size() < 16));
      step;
      t++;
    end
    chk("pay_ready_full", 32'(pay_ready), 0);
    for (int i = 0; i < 16; i++) feed_q.push_back(8'hC0 + 8'(i));
    issue(2'b10, 2'b00, 6'd16);
    expect_pkt(8'h90, 16);
    finish_pkt;
    wait_feed;
    issue(2'b10, 2'b00, 6'd16);
    expect_pkt(8'h90, 16);
    finish_pkt;

    // Reset in the middle of a packet.
    for (int i = 0; i < 3; i++) feed_q.push_back(8'h71 + 8'(i));
    wait_feed;
    issue(2'b00, 2'b00, 6'd3);
    t = 0;
    while (!send_valid && t < 10) begin step; t++; end
    chk("mid_pkt_started", 32'(send_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 32'({busy, send_valid, bus_req, req_ready, pay_ready}), 32'(1));
    chk("mid_reset_count", 32'(dut.fifo_count), 0);
    exp_q.delete();
    pay_model.delete();
    last_sv = 1'b0;
    send_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_reset_req_ready", 32'(req_ready), 0);
    step;
    feed_q.push_back(8'h5A);
    wait_feed;
    issue(2'b11, 2'b11, 6'd1);
    expect_pkt(8'hDC, 1);
    finish_pkt;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
